wr_arb_n: RTL and testbench
===========================

Name: wr_arb_n

Overview:
- N-channel round-robin DDR write arbiter front-end. It replaces the fixed two-requester OR-bus arbitration between frame grabbers and the AXI master.
- Grants whole bursts to requesters, but only when the output FIFO has room for a full burst.
- Buffers write data in an internal FIFO and forwards it to the AXI write engine with channel tags.
- Aggregates per-channel frame-done events into a maskable interrupt, with registers on the internal bus.

Parameters:
- NCH, 2, number of requesting channels (1..8).
- DW, 32, data width of din and m_data.
- BURST_LEN, 16, words per granted burst (2..256).
- FIFO_DEPTH, 64, output FIFO depth in words; power of two, at least 2*BURST_LEN.

Ports:
- clk in 1 system clock
- rst_n in 1 asynchronous active-low reset
- ibus_cs in 1 register chip select
- ibus_wr in 1 1=write, 0=read
- ibus_addr in 8 byte address
- ibus_wrdata in 32 write data
- ibus_rddata out 32 read data, 0 when not selected (OR-bus)
- req in NCH per-channel burst request, level
- frame_end in NCH per-channel flag: the requested burst is the last of the frame; held with req
- ack out NCH one-hot 1-cycle grant pulse
- vin in 1 valid from the OR'd channel data bus
- din in DW OR'd channel data
- m_valid out 1 output word valid
- m_ready in 1 downstream accept
- m_data out DW output word
- m_last out 1 last word of a burst
- m_ch out 3 channel id of the word
- done out NCH 1-cycle pulse when a frame's last burst has been fully accepted into the FIFO
- intr out 1 level interrupt = |(int_stat & int_mask)

Behaviour:
- Reset values: ack, done, m_valid, m_last, m_ch, intr, ibus_rddata all 0. FIFO empty. State IDLE. rr_ptr=0. All registers 0 (channels disabled).
- Reset asserted mid-burst aborts immediately. FIFO contents are discarded and no done pulse is issued.
- Eligible channels: elig = req & en[NCH-1:0].
- IDLE: if elig!=0 and free>=BURST_LEN (free = FIFO_DEPTH - count):
  - Grant the first eligible channel searching from rr_ptr+1 upward with wrap. On the very first grant after reset, the search starts at channel 0.
  - Pulse ack[g] for one cycle, latch g and frame_end[g], set rr_ptr=g, go XFER.
  - The grant decision is registered: ack is asserted the cycle after the condition is seen.
- XFER: each vin cycle writes {g, din, wcnt==BURST_LEN-1} into the FIFO and increments wcnt.
  - After the BURST_LEN-th word: wcnt=0, bump burst_cnt[g]. If latched frame_end, pulse done[g] and set int_stat[g]. Return to IDLE.
  - The earliest next grant is the following cycle, so there is one dead cycle between bursts.
- vin outside XFER is ignored and counted in ovf_cnt (saturating 16-bit).
- FIFO never overflows: admission is guaranteed by the free-space check at grant.
- Output: first-word-fall-through. m_valid = !empty; words pop on m_valid & m_ready.
  - m_ready may stall indefinitely. Grants stall only via the free-space check.
  - A simultaneous push and pop leaves count unchanged.
- The channel going away (req dropped) after ack does not abort the burst; the arbiter waits for BURST_LEN words.
- Disabling a channel in CTRL mid-burst completes that burst.
- Registers (32-bit, bits above NCH read 0):
  - 0x00 CTRL: en[NCH-1:0], RW.
  - 0x04 INT_STAT: RO / W1C. If a set event and a clear coincide on the same bit, set wins.
  - 0x08 INT_MASK: RW.
  - 0x0C STATUS: {16'b0, fifo_count[15:0]}, RO.
  - 0x10 OVF: ovf_cnt, W-any clears.
  - 0x20+4*ch BURST_CNT[ch]: 32-bit wrapping, RO.
  - Unmapped addresses read 0.
- Register reads: ibus_rddata is registered, valid one cycle after ibus_cs & ~ibus_wr, and 0 in all other cycles.
- Register writes take effect the cycle after ibus_cs & ibus_wr.
- intr is registered (one cycle after int_stat/int_mask change).

Test Plan:
- Single channel, NCH=2, BURST_LEN=16, en=01, req[0] held, 16 vin words 0..15, m_ready=1 → one ack[0]; m_data 0..15 with m_ch=0, m_last only on word 15; BURST_CNT[0]=1.
- Both channels, en=11, req=11 continuous → acks alternate 0,1,0,1 over 4 bursts; BURST_CNT[0]=BURST_CNT[1]=2.
- m_ready=0, FIFO_DEPTH=64, req[0] held → exactly 4 acks then none; STATUS=64. Raise m_ready → 5th ack once free>=16.
- frame_end[1]=1 on a burst, int_mask=10 → done[1] pulse after word 16; INT_STAT=2; intr=1 the next cycle. W1C write of 2 → intr=0. W1C coinciding with a new done → bit stays 1.
- vin pulsed 3 times in IDLE → OVF=3; m_valid stays 0. Write to OVF → 0.
- rst_n low after the 8th word of a burst → all outputs 0 immediately; after release, the first grant goes to channel 0.

Source files
------------

// File: rtl/wr_arb_n_if.sv
// Bus bundle for the round-robin DDR write arbiter: register bus, requester
// handshake, shared write-data bus, tagged output stream and event outputs.
interface wr_arb_n_if #(
    parameter int NCH = 2,
    parameter int DW  = 32
);
    logic           ibus_cs;
    logic           ibus_wr;
    logic [7:0]     ibus_addr;
    logic [31:0]    ibus_wrdata;
    logic [31:0]    ibus_rddata;
    logic [NCH-1:0] req;
    logic [NCH-1:0] frame_end;
    logic [NCH-1:0] ack;
    logic           vin;
    logic [DW-1:0]  din;
    logic           m_valid;
    logic           m_ready;
    logic [DW-1:0]  m_data;
    logic           m_last;
    logic [2:0]     m_ch;
    logic [NCH-1:0] done;
    logic           intr;

    // arbiter side
    modport slave (
        input  ibus_cs, ibus_wr, ibus_addr, ibus_wrdata, req, frame_end, vin, din, m_ready,
        output ibus_rddata, ack, m_valid, m_data, m_last, m_ch, done, intr
    );

    // requesters / register master / downstream engine side
    modport master (
        output ibus_cs, ibus_wr, ibus_addr, ibus_wrdata, req, frame_end, vin, din, m_ready,
        input  ibus_rddata, ack, m_valid, m_data, m_last, m_ch, done, intr
    );
endinterface

// File: rtl/wr_arb_n.sv
// N-channel round-robin write arbiter: grants whole bursts when the FWFT output
// FIFO has room for one, tags words with the channel id, raises frame-done irqs.
module wr_arb_n_ch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        set,
    input  logic        clr,
    output logic [31:0] burst_cnt,
    output logic        stat
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
            stat      <= 1'b0;
        end else begin
            if (inc) burst_cnt <= burst_cnt + 32'd1;
            // a new event beats a coincident W1C
            if (set)      stat <= 1'b1;
            else if (clr) stat <= 1'b0;
        end
    end
endmodule

module wr_arb_n #(
    parameter int NCH        = 2,
    parameter int DW         = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input logic       clk,
    input logic       rst_n,
    wr_arb_n_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BURST_LEN);
    localparam int FW = DW + 4;

    typedef enum logic [0:0] {IDLE, XFER} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             rr_ptr, g_q, gnt;
    logic                   fe_q, first_q, grant_ok, room;
    logic [CW-1:0]          wcnt;
    logic [NCH-1:0]         en, mask, int_stat, elig, gnt_oh, ack_q, done_q;
    logic [15:0]            ovf_cnt;
    logic [NCH-1:0][31:0]   burst_cnt;
    logic [AW:0]            count;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [FW-1:0]          mem [FIFO_DEPTH];
    logic [FW-1:0]          rd_word;
    logic                   push, pop, last_word, burst_end, empty, intr_q;
    logic                   reg_wr, reg_rd;
    logic [31:0]            rd_d, rddata_q;
    logic                   unused_ok;

    assign elig      = bus.req & en;
    assign room      = count <= (AW+1)'(FIFO_DEPTH - BURST_LEN);
    assign last_word = wcnt == CW'(BURST_LEN - 1);
    assign push      = (state_q == XFER) && bus.vin;
    assign burst_end = push && last_word;
    assign empty     = count == '0;
    assign pop       = !empty && bus.m_ready;
    assign reg_wr    = bus.ibus_cs && bus.ibus_wr;
    assign reg_rd    = bus.ibus_cs && !bus.ibus_wr;
    assign unused_ok = &{1'b0, bus.ibus_wrdata};

    // Round-robin pick: smallest wrapped distance from the search start wins.
    always_comb begin
        int start, d, best;
        gnt   = '0;
        start = first_q ? 0 : int'(rr_ptr) + 1;
        if (start >= NCH) start = start - NCH;
        best  = NCH;
        for (int j = 0; j < NCH; j++) begin
            d = j - start;
            if (d < 0) d = d + NCH;
            if (elig[j] && d < best) begin
                best = d;
                gnt  = 3'(j);
            end
        end
    end

    assign gnt_oh = NCH'(1) << gnt;

    always_comb begin
        state_d  = state_q;
        grant_ok = 1'b0;
        case (state_q)
            IDLE: if (|elig && room) begin
                grant_ok = 1'b1;
                state_d  = XFER;
            end
            XFER: if (burst_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            g_q     <= '0;
            fe_q    <= 1'b0;
            first_q <= 1'b1;
            wcnt    <= '0;
            ack_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= grant_ok ? gnt_oh : '0;
            done_q  <= (burst_end && fe_q) ? (NCH'(1) << g_q) : '0;
            if (grant_ok) begin
                g_q     <= gnt;
                rr_ptr  <= gnt;
                fe_q    <= |(bus.frame_end & gnt_oh);
                first_q <= 1'b0;
            end
            if (push) wcnt <= last_word ? '0 : wcnt + CW'(1);
        end
    end

    // FWFT FIFO; storage is not reset, occupancy is
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {g_q, bus.din, last_word};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
        end
    end

    assign rd_word     = mem[rd_ptr];
    assign bus.m_valid = !empty;
    assign bus.m_ch    = empty ? 3'd0 : rd_word[FW-1 -: 3];
    assign bus.m_data  = empty ? '0 : rd_word[DW:1];
    assign bus.m_last  = !empty && rd_word[0];

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            wr_arb_n_ch u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc       (burst_end && g_q == 3'(i)),
                .set       (burst_end && fe_q && g_q == 3'(i)),
                .clr       (reg_wr && bus.ibus_addr == 8'h04 && bus.ibus_wrdata[i]),
                .burst_cnt (burst_cnt[i]),
                .stat      (int_stat[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= '0;
            mask     <= '0;
            ovf_cnt  <= '0;
            rddata_q <= '0;
            intr_q   <= 1'b0;
        end else begin
            if (reg_wr && bus.ibus_addr == 8'h00) en   <= bus.ibus_wrdata[NCH-1:0];
            if (reg_wr && bus.ibus_addr == 8'h08) mask <= bus.ibus_wrdata[NCH-1:0];
            if (reg_wr && bus.ibus_addr == 8'h10)
                ovf_cnt <= '0;
            else if (bus.vin && state_q != XFER && ovf_cnt != 16'hffff)
                ovf_cnt <= ovf_cnt + 16'd1;
            rddata_q <= reg_rd ? rd_d : '0;
            intr_q   <= |(int_stat & mask);
        end
    end

    always_comb begin
        rd_d = '0;
        case (bus.ibus_addr)
            8'h00: rd_d[NCH-1:0] = en;
            8'h04: rd_d[NCH-1:0] = int_stat;
            8'h08: rd_d[NCH-1:0] = mask;
            8'h0C: rd_d = 32'(count);
            8'h10: rd_d = 32'(ovf_cnt);
            default: begin
                for (int j = 0; j < NCH; j++)
                    if (bus.ibus_addr == 8'(32 + 4 * j)) rd_d = burst_cnt[j];
            end
        endcase
    end

    assign bus.ack         = ack_q;
    assign bus.done        = done_q;
    assign bus.intr        = intr_q;
    assign bus.ibus_rddata = rddata_q;
endmodule

// File: tb/tb_wr_arb_n.sv
// Directed bench for wr_arb_n: grants, round-robin order, FIFO back-pressure,
// frame-done interrupts, overflow counting and mid-burst reset.
module tb_wr_arb_n;
    localparam int NCH = 2, DW = 32, BL = 16, FD = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wr_arb_n_if #(.NCH(NCH), .DW(DW)) bus ();
    wr_arb_n #(.NCH(NCH), .DW(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0, n_err = 0;
    int ack_log[$];
    logic [35:0] out_log[$];

    always @(negedge clk) begin
        if (rst_n) begin
            for (int j = 0; j < NCH; j++) if (bus.ack[j]) ack_log.push_back(j);
            if (bus.m_valid && bus.m_ready) out_log.push_back({bus.m_ch, bus.m_last, bus.m_data});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        bus.ibus_cs = 1'b1; bus.ibus_wr = 1'b1; bus.ibus_addr = a; bus.ibus_wrdata = d;
        tick();
        bus.ibus_cs = 1'b0; bus.ibus_wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
        bus.ibus_cs = 1'b1; bus.ibus_wr = 1'b0; bus.ibus_addr = a;
        tick();
        d = bus.ibus_rddata;
        bus.ibus_cs = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.ibus_cs = 0; bus.ibus_wr = 0; bus.ibus_addr = 0; bus.ibus_wrdata = 0;
        bus.req = 0; bus.frame_end = 0; bus.vin = 0; bus.din = 0; bus.m_ready = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        ack_log.delete();
        out_log.delete();
    endtask

    task automatic wait_ack(input int lim, output int ch, output bit got);
        got = 1'b0;
        ch  = -1;
        for (int i = 0; i < lim && !got; i++) begin
            tick();
            if (|bus.ack) begin
                got = 1'b1;
                for (int j = 0; j < NCH; j++) if (bus.ack[j]) ch = j;
            end
        end
    endtask

    task automatic send_burst(input int base, input bit w1c_last);
        for (int i = 0; i < BL; i++) begin
            bus.vin = 1'b1;
            bus.din = 32'(base + i);
            if (w1c_last && i == BL - 1) begin
                bus.ibus_cs = 1'b1; bus.ibus_wr = 1'b1; bus.ibus_addr = 8'h04; bus.ibus_wrdata = 32'd2;
            end
            tick();
        end
        bus.vin = 1'b0;
        bus.ibus_cs = 1'b0; bus.ibus_wr = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int ch;
        bit got;

        // reset state
        do_reset();
        chk("rst_ack", bus.ack, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mvalid", bus.m_valid, 0);
        chk("rst_mlast", bus.m_last, 0);
        chk("rst_mch", bus.m_ch, 0);
        chk("rst_intr", bus.intr, 0);
        chk("rst_rddata", bus.ibus_rddata, 0);
        reg_rd(8'h00, rd); chk("rst_ctrl", rd, 0);
        reg_rd(8'h0C, rd); chk("rst_status", rd, 0);
        tick(); chk("rddata_idle", bus.ibus_rddata, 0);

        // single channel burst
        reg_wr(8'h00, 32'h1);
        bus.m_ready = 1'b1;
        bus.req = 2'b01;
        wait_ack(50, ch, got);
        chk("t1_ack_seen", got, 1);
        chk("t1_ack_ch", ch, 0);
        send_burst(0, 1'b0);
        bus.req = 2'b00;
        repeat (20) tick();
        chk("t1_nacks", ack_log.size(), 1);
        chk("t1_nwords", out_log.size(), 16);
        for (int i = 0; i < BL; i++)
            if (i < out_log.size()) chk("t1_word", out_log[i], {3'd0, (i == BL - 1), 32'(i)});
        reg_rd(8'h20, rd); chk("t1_bcnt0", rd, 1);

        // two channels, round-robin
        do_reset();
        reg_wr(8'h00, 32'h3);
        bus.m_ready = 1'b1;
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(50, ch, got);
            chk("t2_ack_seen", got, 1);
            if (k == 3) bus.req = 2'b00;
            send_burst(100 * k, 1'b0);
            bus.req = (k == 3) ? 2'b00 : 2'b11;
        end
        repeat (20) tick();
        chk("t2_nacks", ack_log.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < ack_log.size()) chk("t2_ack_order", ack_log[k], k % 2);
        chk("t2_nwords", out_log.size(), 64);
        if (out_log.size() > 16) chk("t2_word16", out_log[16], {3'd1, 1'b0, 32'd100});
        reg_rd(8'h20, rd); chk("t2_bcnt0", rd, 2);
        reg_rd(8'h24, rd); chk("t2_bcnt1", rd, 2);
        reg_rd(8'h28, rd); chk("t2_unmapped28", rd, 0);
        reg_rd(8'h40, rd); chk("t2_unmapped40", rd, 0);

        // back-pressure: FIFO fills after four bursts
        do_reset();
        reg_wr(8'h00, 32'h1);
        bus.req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            wait_ack(50, ch, got);
            chk("t3_ack_seen", got, 1);
            send_burst(16 * k, 1'b0);
        end
        wait_ack(40, ch, got);
        chk("t3_no_5th", got, 0);
        reg_rd(8'h0C, rd); chk("t3_status", rd, 64);
        chk("t3_mvalid", bus.m_valid, 1);
        out_log.delete();
        bus.m_ready = 1'b1;
        wait_ack(60, ch, got);
        chk("t3_5th_ack", got, 1);
        chk("t3_pops_at_ack", out_log.size(), 17);
        send_burst(64, 1'b0);
        bus.req = 2'b00;
        repeat (100) tick();
        reg_rd(8'h0C, rd); chk("t3_drained", rd, 0);

        // frame-done interrupt and W1C
        do_reset();
        reg_wr(8'h00, 32'h2);
        reg_wr(8'h08, 32'h2);
        bus.m_ready = 1'b1;
        bus.req = 2'b10; bus.frame_end = 2'b10;
        wait_ack(50, ch, got);
        chk("t4_ack_ch", ch, 1);
        send_burst(0, 1'b0);
        bus.req = 2'b00; bus.frame_end = 2'b00;
        chk("t4_done", bus.done, 2);
        chk("t4_intr_pre", bus.intr, 0);
        tick();
        chk("t4_intr", bus.intr, 1);
        chk("t4_done_pulse", bus.done, 0);
        reg_rd(8'h04, rd); chk("t4_stat", rd, 2);
        reg_wr(8'h04, 32'h2);
        tick();
        chk("t4_intr_clr", bus.intr, 0);
        bus.req = 2'b10; bus.frame_end = 2'b10;
        wait_ack(50, ch, got);
        chk("t4_ack2", got, 1);
        send_burst(0, 1'b1);
        bus.req = 2'b00; bus.frame_end = 2'b00;
        reg_rd(8'h04, rd); chk("t4_set_wins", rd, 2);
        chk("t4_intr2", bus.intr, 1);
        reg_rd(8'h20 + 8'h04, rd); chk("t4_bcnt1", rd, 2);

        // vin outside a burst
        do_reset();
        bus.m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.vin = 1'b1; bus.din = 32'hdead;
            tick();
            bus.vin = 1'b0;
            tick();
        end
        chk("t5_mvalid", bus.m_valid, 0);
        reg_rd(8'h10, rd); chk("t5_ovf", rd, 3);
        reg_wr(8'h10, 32'h0);
        reg_rd(8'h10, rd); chk("t5_ovf_clr", rd, 0);

        // reset in the middle of a burst
        do_reset();
        reg_wr(8'h00, 32'h3);
        reg_wr(8'h08, 32'h3);
        bus.req = 2'b10; bus.frame_end = 2'b10;
        wait_ack(50, ch, got);
        chk("t6_ack_ch1", ch, 1);
        for (int i = 0; i < 8; i++) begin
            bus.vin = 1'b1; bus.din = 32'(i + 1);
            tick();
        end
        chk("t6_mvalid_pre", bus.m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_mvalid", bus.m_valid, 0);
        chk("t6_rst_mdata", bus.m_data, 0);
        chk("t6_rst_ack", bus.ack, 0);
        chk("t6_rst_done", bus.done, 0);
        chk("t6_rst_intr", bus.intr, 0);
        bus.vin = 1'b0; bus.req = 2'b00; bus.frame_end = 2'b00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        ack_log.delete();
        out_log.delete();
        reg_rd(8'h0C, rd); chk("t6_status", rd, 0);
        chk("t6_done_none", bus.done, 0);
        reg_wr(8'h00, 32'h3);
        bus.m_ready = 1'b1;
        bus.req = 2'b11;
        wait_ack(50, ch, got);
        chk("t6_first_ch0", ch, 0);
        bus.req = 2'b00;
        send_burst(0, 1'b0);
        repeat (20) tick();
        chk("t6_nwords", out_log.size(), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
